halt_controller: RTL

- Sequences simulation/core termination for the single-issue RV core.
- Detects a retiring ebreak, an unknown instruction, or a retire-watchdog expiry, then captures the PC and exit code and freezes fetch.
- Drains the pipeline, waits for fetch/LSU bus idle (bounded by a timeout), and then emits a one-cycle exit pulse plus a sticky halt report.
- Sits between the decode/retire stage, the IFU/LSU, and the simulation-exit/DPI consumer.

---
 rtl/halt_controller.sv | 119 +++++++++++
 1 files changed

// File: rtl/halt_controller.sv
// Termination sequencer for the single-issue RV core: captures the halt cause on
// ebreak / unknown instruction / retire-watchdog, drains the pipeline, waits for bus idle, reports.
module halt_controller #(
   parameter int unsigned DRAIN_CYCLES   = 3,
   parameter int unsigned MEM_TIMEOUT    = 255,
   parameter int unsigned WATCHDOG_LIMIT = 1000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        retire_valid,
   input  logic [31:0] retire_pc,
   input  logic        is_break_out,
   input  logic        is_unknown_instruction,
   input  logic [31:0] a0_value,
   input  logic        ifu_busy,
   input  logic        lsu_busy,
   output logic        stall_req,
   output logic        halt_valid,
   output logic [31:0] halt_pc,
   output logic [31:0] halt_code,
   output logic [1:0]  halt_cause,
   output logic        good_trap,
   output logic        mem_timeout,
   output logic        sim_exit
);

   typedef enum logic [2:0] {RUN, DRAIN, WAIT_MEM, REPORT, HALTED} state_t;

   localparam logic [3:0]  DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);
   localparam logic [15:0] MEM_LAST   = 16'(MEM_TIMEOUT - 1);
   localparam logic [31:0] WD_LAST    = 32'(WATCHDOG_LIMIT - 1);
   localparam bit          WD_ENABLE  = (WATCHDOG_LIMIT != 0);

   state_t      state, state_nxt;
   logic [3:0]  drain_cnt;
   logic [15:0] mem_cnt;
   logic [31:0] wd_cnt;
   logic        trigger, wd_fire, bus_idle;
   logic        capture_retire, capture_wd, timeout_hit;

   assign trigger  = retire_valid & (is_unknown_instruction | is_break_out);
   assign wd_fire  = WD_ENABLE & ~retire_valid & (wd_cnt == WD_LAST);
   assign bus_idle = ~ifu_busy & ~lsu_busy;

   // NOTE: every signal gets a default before the case so no path can infer a latch.
   always_comb begin
      state_nxt      = state;
      capture_retire = 1'b0;
      capture_wd     = 1'b0;
      timeout_hit    = 1'b0;
      case (state)
         RUN: begin
            if (trigger) begin
               capture_retire = 1'b1;
               state_nxt      = DRAIN;
            end else if (wd_fire) begin
               capture_wd = 1'b1;
               state_nxt  = DRAIN;
            end
         end
         DRAIN:    if (drain_cnt == 4'd0) state_nxt = WAIT_MEM;
         WAIT_MEM: begin
            if (bus_idle) begin
               state_nxt = REPORT;
            end else if (mem_cnt == MEM_LAST) begin
               timeout_hit = 1'b1;
               state_nxt   = REPORT;
            end
         end
         REPORT:   state_nxt = HALTED;
         HALTED:   state_nxt = HALTED;
         default:  state_nxt = RUN;
      endcase
   end

   assign stall_req  = (state != RUN);
   assign halt_valid = (state == REPORT) || (state == HALTED);
   assign sim_exit   = (state == REPORT);
   assign good_trap  = halt_valid && (halt_cause == 2'd1) && (halt_code == 32'd0);

   // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= RUN;
         drain_cnt   <= '0;
         mem_cnt     <= '0;
         wd_cnt      <= '0;
         halt_pc     <= '0;
         halt_code   <= '0;
         halt_cause  <= '0;
         mem_timeout <= 1'b0;
      end else begin
         state <= state_nxt;

         if (retire_valid)       wd_cnt <= '0;
         else if (wd_cnt != '1) wd_cnt <= wd_cnt + 32'd1;

         if (capture_retire) begin
            halt_pc    <= retire_pc;
            halt_code  <= a0_value;
            halt_cause <= is_unknown_instruction ? 2'd2 : 2'd1;
            drain_cnt  <= DRAIN_LOAD;
         end else if (capture_wd) begin
            halt_pc    <= retire_pc;
            halt_code  <= 32'hFFFF_FFFF;
            halt_cause <= 2'd3;
            drain_cnt  <= DRAIN_LOAD;
         end else if (state == DRAIN && drain_cnt != 4'd0) begin
            drain_cnt <= drain_cnt - 4'd1;
         end

         // Counter only matters while the bus is busy; an idle bus leaves WAIT_MEM anyway.
         mem_cnt <= (state == WAIT_MEM) ? mem_cnt + 16'd1 : 16'd0;

         if (timeout_hit) mem_timeout <= 1'b1;
      end
   end

endmodule
